// File: rtl/xor5_pkg.sv
// Shared definitions for the XOR5 parity link receive side.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package xor5_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Link frame: four data bits plus one parity bit.
    localparam int FRAME_W = 5;

    // Three-input majority, the primitive of the link's parity gate library.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/xor5_frame_checker_if.sv
// Bundles for the XOR5 frame checker: a serial bit stream in and a word out.
// Latency: n/a (wiring only).
// Backpressure: s_ready throttles the bit stream; m_ready throttles the word.
//
// xor5_serial_if : s_valid/s_sof/s_bit from the master, s_ready from the slave.
// xor5_word_if   : m_valid/m_data/m_perr from the master, m_ready from the slave.

interface xor5_serial_if;
    logic s_valid;
    logic s_sof;
    logic s_bit;
    logic s_ready;

    modport master (output s_valid, output s_sof, output s_bit, input  s_ready);
    modport slave  (input  s_valid, input  s_sof, input  s_bit, output s_ready);
endinterface

interface xor5_word_if #(
    parameter int DATA_W = xor5_pkg::FRAME_W - 1
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_perr;

    modport master (output m_valid, output m_data, output m_perr, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_perr, output m_ready);
endinterface

// File: rtl/maj_xor_step.sv
// Two-input XOR built from three majority gates, matching the transmit-side generator.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: i_a, i_b - operands; o_y - i_a ^ i_b.
module maj_xor_step
    import xor5_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);

    logic w_a_nb;   // a & ~b
    logic w_na_b;   // ~a & b

    // A majority gate with one input tied low is an AND; tied high it is an OR.
    assign w_a_nb = maj3(i_a, ~i_b, 1'b0);
    assign w_na_b = maj3(~i_a, i_b, 1'b0);
    assign o_y    = maj3(w_a_nb, w_na_b, 1'b1);

endmodule

// File: rtl/xor5_frame_checker.sv
// Deserialises LSB-first frames (DATA_W data + 1 parity bit), checks parity, presents the word.
// Latency: m_valid rises 1 cycle after the parity bit is accepted; FRAME_W+1 cycles/frame minimum.
// Backpressure: s_ready is registered and low while a word waits for m_ready; no comb path m_ready->s_ready.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   s          - serial bit stream (s_valid, s_sof, s_bit in; s_ready out)
//   m          - received word (m_valid, m_data, m_perr out; m_ready in)
//   clr_cnt    - synchronous clear of both counters, wins over a same-cycle increment
//   perr_cnt   - saturating count of frames delivered with m_perr=1
//   abort_cnt  - saturating count of partial frames abandoned by a new s_sof
module xor5_frame_checker
    import xor5_pkg::*;
#(
    parameter int DATA_W     = FRAME_W - 1,
    parameter int CNT_W      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    xor5_serial_if.slave     s,
    xor5_word_if.master      m,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] perr_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int                LP_FRAME_W = DATA_W + 1;
    localparam int                LP_IDX_W   = $clog2(LP_FRAME_W);
    localparam logic [LP_IDX_W-1:0] LP_LAST  = LP_IDX_W'(DATA_W);

    state_t              r_state;
    logic [LP_IDX_W-1:0] r_idx;
    logic                r_p;
    logic [DATA_W-1:0]   r_data;
    logic                r_perr;
    logic                r_valid;
    logic                r_s_ready;
    logic [CNT_W-1:0]    r_perr_cnt;
    logic [CNT_W-1:0]    r_abort_cnt;

    logic                w_acc;
    logic                w_p_next;
    logic                w_perr_new;
    logic                w_frame_done;
    logic                w_abort;
    logic [DATA_W-1:0]   w_data_upd;

    assign w_acc = s.s_valid && r_s_ready;

    maj_xor_step u_parity_step (
        .i_a (r_p),
        .i_b (s.s_bit),
        .o_y (w_p_next)
    );

    // On the parity bit, w_p_next is the XOR of the whole frame.
    assign w_perr_new   = w_p_next ^ PARITY_ODD;
    assign w_abort      = w_acc && s.s_sof && (r_state == SHIFT);
    assign w_frame_done = w_acc && !s.s_sof && (r_state == SHIFT) && (r_idx == LP_LAST);

    // Write the incoming bit at the current index; other bits keep their (possibly stale) value.
    always_comb begin
        w_data_upd = r_data;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_idx == LP_IDX_W'(i)) begin
                w_data_upd[i] = s.s_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_p         <= 1'b0;
            r_data      <= '0;
            r_perr      <= 1'b0;
            r_valid     <= 1'b0;
            r_s_ready   <= 1'b1;
            r_perr_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Bits without a start of frame are dropped here.
                    if (w_acc && s.s_sof) begin
                        r_data[0] <= s.s_bit;
                        r_p       <= s.s_bit;
                        r_idx     <= LP_IDX_W'(1);
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_acc) begin
                        if (s.s_sof) begin
                            // Abandon the partial frame and restart on this bit.
                            r_data[0] <= s.s_bit;
                            r_p       <= s.s_bit;
                            r_idx     <= LP_IDX_W'(1);
                        end else if (r_idx != LP_LAST) begin
                            r_data <= w_data_upd;
                            r_p    <= w_p_next;
                            r_idx  <= r_idx + 1'b1;
                        end else begin
                            r_perr    <= w_perr_new;
                            r_valid   <= 1'b1;
                            r_s_ready <= 1'b0;
                            r_idx     <= '0;
                            r_state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (m.m_ready) begin
                        r_valid   <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_valid   <= 1'b0;
                    r_s_ready <= 1'b1;
                end
            endcase

            if (clr_cnt) begin
                r_perr_cnt <= '0;
            end else if (w_frame_done && w_perr_new && (r_perr_cnt != '1)) begin
                r_perr_cnt <= r_perr_cnt + 1'b1;
            end

            if (clr_cnt) begin
                r_abort_cnt <= '0;
            end else if (w_abort && (r_abort_cnt != '1)) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end
        end
    end

    assign s.s_ready = r_s_ready;
    assign m.m_valid = r_valid;
    assign m.m_data  = r_data;
    assign m.m_perr  = r_perr;
    assign perr_cnt  = r_perr_cnt;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_xor5_frame_checker.sv
// Self-checking bench: three checker instances (even/8-bit, odd/8-bit, even/2-bit counters)
// share one stimulus stream and are compared against a frame-level reference model.
module tb_xor5_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic t_rst, t_valid, t_sof, t_bit, t_mr, t_clr;

    xor5_serial_if   sif_e ();
    xor5_serial_if   sif_o ();
    xor5_serial_if   sif_s ();
    xor5_word_if #(4) wif_e ();
    xor5_word_if #(4) wif_o ();
    xor5_word_if #(4) wif_s ();

    assign sif_e.s_valid = t_valid; assign sif_e.s_sof = t_sof; assign sif_e.s_bit = t_bit;
    assign sif_o.s_valid = t_valid; assign sif_o.s_sof = t_sof; assign sif_o.s_bit = t_bit;
    assign sif_s.s_valid = t_valid; assign sif_s.s_sof = t_sof; assign sif_s.s_bit = t_bit;
    assign wif_e.m_ready = t_mr;
    assign wif_o.m_ready = t_mr;
    assign wif_s.m_ready = t_mr;

    logic [7:0] perr_e, abort_e, perr_o, abort_o;
    logic [1:0] perr_s, abort_s;

    xor5_frame_checker #(.DATA_W(4), .CNT_W(8), .PARITY_ODD(1'b0)) u_dut_e (
        .clk(clk), .rst(t_rst), .s(sif_e), .m(wif_e), .clr_cnt(t_clr),
        .perr_cnt(perr_e), .abort_cnt(abort_e));
    xor5_frame_checker #(.DATA_W(4), .CNT_W(8), .PARITY_ODD(1'b1)) u_dut_o (
        .clk(clk), .rst(t_rst), .s(sif_o), .m(wif_o), .clr_cnt(t_clr),
        .perr_cnt(perr_o), .abort_cnt(abort_o));
    xor5_frame_checker #(.DATA_W(4), .CNT_W(2), .PARITY_ODD(1'b0)) u_dut_s (
        .clk(clk), .rst(t_rst), .s(sif_s), .m(wif_s), .clr_cnt(t_clr),
        .perr_cnt(perr_s), .abort_cnt(abort_s));

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model (frame level) ----------------
    bit       md_hold, md_in, md_valid, md_perr_e, md_perr_o;
    bit [3:0] md_data;
    bit       md_q[$];
    int       pc_e, pc_o, pc_s, ac_8, ac_2;

    task automatic model_edge(input bit v, input bit sof, input bit b,
                              input bit mr, input bit clr, input bit rst);
        bit inc_e, inc_o, inc_ab, x;
        inc_e = 0; inc_o = 0; inc_ab = 0;
        if (rst) begin
            md_hold = 0; md_in = 0; md_valid = 0; md_data = 0;
            md_perr_e = 0; md_perr_o = 0; md_q.delete();
            pc_e = 0; pc_o = 0; pc_s = 0; ac_8 = 0; ac_2 = 0;
            return;
        end
        if (md_hold) begin
            if (mr) begin md_hold = 0; md_valid = 0; end
        end else if (v) begin
            if (sof) begin
                if (md_in) inc_ab = 1;
                md_q.delete();
                md_q.push_back(b);
                md_in = 1;
            end else if (md_in) begin
                md_q.push_back(b);
                if (md_q.size() == 5) begin
                    x = 0;
                    foreach (md_q[i]) x ^= md_q[i];
                    for (int i = 0; i < 4; i++) md_data[i] = md_q[i];
                    md_perr_e = x; md_perr_o = ~x;
                    inc_e = x; inc_o = ~x;
                    md_valid = 1; md_hold = 1; md_in = 0;
                    md_q.delete();
                end
            end
        end
        if (clr) begin
            pc_e = 0; pc_o = 0; pc_s = 0; ac_8 = 0; ac_2 = 0;
        end else begin
            if (inc_e) begin
                if (pc_e != 255) pc_e++;
                if (pc_s != 3) pc_s++;
            end
            if (inc_o && pc_o != 255) pc_o++;
            if (inc_ab) begin
                if (ac_8 != 255) ac_8++;
                if (ac_2 != 3) ac_2++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic step(input bit v, input bit sof, input bit b,
                        input bit mr, input bit clr, input bit rst);
        t_valid = v; t_sof = sof; t_bit = b; t_mr = mr; t_clr = clr; t_rst = rst;
        @(posedge clk);
        model_edge(v, sof, b, mr, clr, rst);
        #1;
    endtask

    // Send a full frame, fb[0] first with sof; clr_last asserts clr_cnt with the parity bit.
    task automatic send_frame(input logic [4:0] fb, input bit clr_last);
        for (int i = 0; i < 5; i++)
            step(1'b1, (i == 0), fb[i], 1'b0, (i == 4) && clr_last, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        t_rst = 1'b0;
        n_tests++; if (sif_e.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b exp 1", sif_e.s_ready); end
        n_tests++; if (wif_e.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b exp 0", wif_e.m_valid); end
        n_tests++; if (wif_e.m_data !== 4'h0) begin n_fail++; $display("FAIL reset_m_data got %h exp 0", wif_e.m_data); end
        n_tests++; if (wif_e.m_perr !== 1'b0) begin n_fail++; $display("FAIL reset_m_perr got %b exp 0", wif_e.m_perr); end
        n_tests++; if (perr_e !== 8'd0 || abort_e !== 8'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", perr_e, abort_e); end
        n_tests++; if (perr_s !== 2'd0 || abort_s !== 2'd0) begin n_fail++; $display("FAIL reset_counters_small got %0d/%0d exp 0/0", perr_s, abort_s); end
    endtask

    task automatic test_good_frame();
        for (int i = 0; i < 4; i++) step(1, (i == 0), i != 2, 0, 0, 0);
        n_tests++; if (wif_e.m_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid got %b exp 0", wif_e.m_valid); end
        step(1, 0, 1, 0, 0, 0);
        n_tests++; if (wif_e.m_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %b exp 1", wif_e.m_valid); end
        n_tests++; if (wif_e.m_data !== 4'hB) begin n_fail++; $display("FAIL good_data got %h exp b", wif_e.m_data); end
        n_tests++; if (wif_e.m_perr !== 1'b0) begin n_fail++; $display("FAIL good_perr got %b exp 0", wif_e.m_perr); end
        n_tests++; if (perr_e !== 8'd0) begin n_fail++; $display("FAIL good_perr_cnt got %0d exp 0", perr_e); end
        n_tests++; if (wif_o.m_perr !== 1'b1) begin n_fail++; $display("FAIL good_odd_perr got %b exp 1", wif_o.m_perr); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_bad_parity();
        send_frame(5'b01011, 0);
        n_tests++; if (wif_e.m_valid !== 1'b1 || wif_e.m_data !== 4'hB) begin n_fail++; $display("FAIL bad_word got %b/%h exp 1/b", wif_e.m_valid, wif_e.m_data); end
        n_tests++; if (wif_e.m_perr !== 1'b1) begin n_fail++; $display("FAIL bad_perr got %b exp 1", wif_e.m_perr); end
        n_tests++; if (perr_e !== 8'd1) begin n_fail++; $display("FAIL bad_perr_cnt got %0d exp 1", perr_e); end
        n_tests++; if (wif_o.m_perr !== 1'b0) begin n_fail++; $display("FAIL bad_odd_perr got %b exp 0", wif_o.m_perr); end
        n_tests++; if (perr_o !== 8'(pc_o)) begin n_fail++; $display("FAIL bad_odd_perr_cnt got %0d exp %0d", perr_o, pc_o); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_backpressure();
        send_frame(5'b11011, 0);
        for (int c = 0; c < 3; c++) begin
            step(1, c == 1, 1'(c), 0, 0, 0);
            n_tests++; if (sif_e.s_ready !== 1'b0) begin n_fail++; $display("FAIL hold_s_ready got %b exp 0", sif_e.s_ready); end
            n_tests++; if (wif_e.m_valid !== 1'b1 || wif_e.m_data !== 4'hB || wif_e.m_perr !== 1'b0)
                begin n_fail++; $display("FAIL hold_stable got %b/%h/%b exp 1/b/0", wif_e.m_valid, wif_e.m_data, wif_e.m_perr); end
        end
        step(1, 1, 0, 1, 0, 0);
        n_tests++; if (wif_e.m_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid got %b exp 0", wif_e.m_valid); end
        n_tests++; if (sif_e.s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready got %b exp 1", sif_e.s_ready); end
        n_tests++; if (abort_e !== 8'd0) begin n_fail++; $display("FAIL hold_abort_cnt got %0d exp 0", abort_e); end
    endtask

    task automatic test_abort();
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        send_frame(5'b01100, 0);
        n_tests++; if (abort_e !== 8'd1) begin n_fail++; $display("FAIL abort_cnt got %0d exp 1", abort_e); end
        n_tests++; if (wif_e.m_valid !== 1'b1 || wif_e.m_data !== 4'hC) begin n_fail++; $display("FAIL abort_word got %b/%h exp 1/c", wif_e.m_valid, wif_e.m_data); end
        n_tests++; if (wif_e.m_perr !== 1'b0) begin n_fail++; $display("FAIL abort_perr got %b exp 0", wif_e.m_perr); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 0, 1, 0);
        for (int f = 0; f < 6; f++) begin
            send_frame(5'b01011, 0);
            step(0, 0, 0, 1, 0, 0);
        end
        n_tests++; if (perr_s !== 2'd3) begin n_fail++; $display("FAIL sat_small got %0d exp 3", perr_s); end
        n_tests++; if (perr_e !== 8'd6) begin n_fail++; $display("FAIL sat_wide got %0d exp 6", perr_e); end
        send_frame(5'b01011, 1);
        n_tests++; if (perr_s !== 2'd0 || perr_e !== 8'd0) begin n_fail++; $display("FAIL clr_priority got %0d/%0d exp 0/0", perr_s, perr_e); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_midframe();
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);  // restart: one abort
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        n_tests++; if (sif_e.s_ready !== 1'b1 || wif_e.m_valid !== 1'b0 || wif_e.m_data !== 4'h0 || wif_e.m_perr !== 1'b0)
            begin n_fail++; $display("FAIL midrst_outputs got %b/%b/%h/%b exp 1/0/0/0", sif_e.s_ready, wif_e.m_valid, wif_e.m_data, wif_e.m_perr); end
        n_tests++; if (abort_e !== 8'd0) begin n_fail++; $display("FAIL midrst_abort got %0d exp 0", abort_e); end
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        n_tests++; if (wif_e.m_valid !== 1'b0 || wif_e.m_data !== 4'h0) begin n_fail++; $display("FAIL drop_nonsof got %b/%h exp 0/0", wif_e.m_valid, wif_e.m_data); end
        send_frame(5'b00110, 0);
        n_tests++; if (wif_e.m_valid !== 1'b1 || wif_e.m_data !== 4'h6 || wif_e.m_perr !== 1'b0)
            begin n_fail++; $display("FAIL post_rst_frame got %b/%h/%b exp 1/6/0", wif_e.m_valid, wif_e.m_data, wif_e.m_perr); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        bit v, sof, b, mr, clr, rst;
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 9) < 7);
            sof = ($urandom_range(0, 19) < 3);
            b   = 1'($urandom);
            mr  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step(v, sof, b, mr, clr, rst);
            n_tests++; if (sif_e.s_ready !== !md_hold || sif_s.s_ready !== !md_hold)
                begin n_fail++; $display("FAIL rnd_s_ready c=%0d got %b exp %b", c, sif_e.s_ready, !md_hold); end
            n_tests++; if (wif_e.m_valid !== md_valid || wif_o.m_valid !== md_valid)
                begin n_fail++; $display("FAIL rnd_m_valid c=%0d got %b exp %b", c, wif_e.m_valid, md_valid); end
            if (md_valid) begin
                n_tests++; if (wif_e.m_data !== md_data || wif_o.m_data !== md_data)
                    begin n_fail++; $display("FAIL rnd_m_data c=%0d got %h exp %h", c, wif_e.m_data, md_data); end
                n_tests++; if (wif_e.m_perr !== md_perr_e || wif_o.m_perr !== md_perr_o)
                    begin n_fail++; $display("FAIL rnd_m_perr c=%0d got %b/%b exp %b/%b", c, wif_e.m_perr, wif_o.m_perr, md_perr_e, md_perr_o); end
            end
            n_tests++; if (perr_e !== 8'(pc_e) || perr_o !== 8'(pc_o) || perr_s !== 2'(pc_s))
                begin n_fail++; $display("FAIL rnd_perr_cnt c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, perr_e, perr_o, perr_s, pc_e, pc_o, pc_s); end
            n_tests++; if (abort_e !== 8'(ac_8) || abort_s !== 2'(ac_2))
                begin n_fail++; $display("FAIL rnd_abort_cnt c=%0d got %0d/%0d exp %0d/%0d", c, abort_e, abort_s, ac_8, ac_2); end
        end
    endtask

    initial begin
        t_rst = 1'b1; t_valid = 1'b0; t_sof = 1'b0; t_bit = 1'b0; t_mr = 1'b0; t_clr = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_backpressure();
        test_abort();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
